// File: rtl/instr_fetch_queue_pkg.sv
// Shared fetch-stage definitions: widths, default queue depth and the fetch FSM encoding.
package instr_fetch_queue_pkg;

  localparam int XLEN        = 32;
  localparam int FETCH_DEPTH = 2;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Fetch-side buses: PC/instruction-memory port and the valid/ready link toward decode.
interface instr_fetch_queue_if #(
  parameter int XLEN = 32
);

  logic [XLEN-1:0] pc_in;
  logic            pc_advance;
  logic [XLEN-1:0] imem_addr;
  logic            imem_req;
  logic [XLEN-1:0] imem_rdata;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;

  // master = fetch queue, slave = PC register / imem / decode environment
  modport master (
    input  pc_in, imem_rdata, out_ready,
    output pc_advance, imem_addr, imem_req, out_valid, out_pc, out_instr
  );

  modport slave (
    output pc_in, imem_rdata, out_ready,
    input  pc_advance, imem_addr, imem_req, out_valid, out_pc, out_instr
  );

endinterface

// File: rtl/instr_fetch_queue_fifo.sv
// Small power-of-two FIFO of {pc, instr} pairs with synchronous clear and occupancy count.
module instr_fetch_queue_fifo #(
  parameter  int DEPTH = 2,
  parameter  int WIDTH = 64,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wr_ptr;
  logic [AW-1:0]               rd_ptr;

  assign rdata = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // pointers are exactly AW bits wide, so natural overflow is the modulo-DEPTH wrap
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: issues the PC to a 1-cycle imem, buffers {pc, instr} toward decode, handles flush/halt.
module instr_fetch_queue #(
  parameter int DEPTH = instr_fetch_queue_pkg::FETCH_DEPTH,
  parameter int XLEN  = instr_fetch_queue_pkg::XLEN
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush,
  input  logic                halt_req,
  output logic                halted,
  instr_fetch_queue_if.master bus
);

  import instr_fetch_queue_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e      state;
  fetch_state_e      state_nxt;
  logic              inflight;
  logic [XLEN-1:0]   inflight_pc;
  logic              issue;
  logic              push;
  logic              pop;
  logic              credit_ok;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [2*XLEN-1:0] head;

  // A slot is reserved at issue time so the returning word always finds room.
  always_comb begin
    credit_ok = (int'(fifo_count) + int'(inflight)
                 - int'(bus.out_valid & bus.out_ready)) < DEPTH;
  end

  assign issue = ~reset & (state == RUN) & ~flush & ~halt_req & credit_ok;
  assign pop   = bus.out_valid & bus.out_ready & ~flush;
  assign push  = inflight & ~flush;

  assign bus.pc_advance = issue;
  assign bus.imem_req   = issue;
  assign bus.imem_addr  = bus.pc_in;

  assign bus.out_valid = ~fifo_empty;
  assign bus.out_pc    = bus.out_valid ? head[2*XLEN-1:XLEN] : '0;
  assign bus.out_instr = bus.out_valid ? head[XLEN-1:0]      : '0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    halted    = 1'b0;
    case (state)
      RUN: begin
        if (halt_req && !flush) begin
          state_nxt = HALTED;
        end
      end
      HALTED: begin
        halted = 1'b1;
        if (flush) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Tracks the one request whose word arrives on imem_rdata next cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= bus.pc_in;
      end
    end
  end

  instr_fetch_queue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * XLEN)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .clear (flush),
    .push  (push),
    .pop   (pop),
    .wdata ({inflight_pc, bus.imem_rdata}),
    .rdata (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  a_no_overflow: assert property (@(posedge clock) disable iff (reset)
                                  !(push && fifo_full && !pop));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomised scoreboard bench for instr_fetch_queue with a transaction-level fetch model.
module tb_instr_fetch_queue;

  localparam int DEPTH = 2;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } pair_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic halt_req = 1'b0;
  logic halted;

  instr_fetch_queue_if #(.XLEN(32)) bus ();

  instr_fetch_queue #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .flush    (flush),
    .halt_req (halt_req),
    .halted   (halted),
    .bus      (bus)
  );

  always #5 clock = ~clock;

  pair_t       scb[$];
  int          tests = 0;
  int          fails = 0;
  bit          halted_m = 1'b0;
  bit          pend = 1'b0;
  bit          popped = 1'b0;
  logic [31:0] pc_reg = '0;
  logic [31:0] pc_nxt = '0;
  logic [31:0] rd_nxt = '0;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: consumes accepted head entries and checks hold-stability under backpressure.
  logic [31:0] prev_pc;
  logic [31:0] prev_instr;
  bit          prev_stall = 1'b0;

  always @(negedge clock) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk1("hold_valid", bus.out_valid, 1'b1);
        chk32("hold_pc", bus.out_pc, prev_pc);
        chk32("hold_instr", bus.out_instr, prev_instr);
      end
      prev_stall = bus.out_valid && !bus.out_ready && !flush;
      prev_pc    = bus.out_pc;
      prev_instr = bus.out_instr;
      if (bus.out_valid && bus.out_ready && !flush) begin
        popped = 1'b1;
        if (scb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL pop_unexpected: got pc %h expected no entry", bus.out_pc);
        end else begin
          chk32("out_pc", bus.out_pc, scb[0].pc);
          chk32("out_instr", bus.out_instr, scb[0].instr);
          void'(scb.pop_front());
        end
      end
    end
  end

  task automatic drive(input bit f, input bit h, input bit r);
    @(posedge clock);
    #1;
    pc_reg         = pc_nxt;
    bus.pc_in      = pc_nxt;
    bus.imem_rdata = rd_nxt;
    flush          = f;
    halt_req       = h;
    bus.out_ready  = r;
  endtask

  // Checks this cycle's combinational outputs, then advances the PC/imem/scoreboard model.
  task automatic check_update(input logic [31:0] tgt);
    int occ;
    bit exp_adv;
    bit exp_vld;
    @(negedge clock);
    #2;
    occ     = scb.size();
    exp_vld = popped || (occ > (pend ? 1 : 0));
    exp_adv = !halted_m && !flush && !halt_req && (occ < DEPTH);
    chk1("pc_advance", bus.pc_advance, exp_adv);
    chk1("imem_req", bus.imem_req, exp_adv);
    chk32("imem_addr", bus.imem_addr, pc_reg);
    chk1("out_valid", bus.out_valid, exp_vld);
    chk1("halted", halted, halted_m);
    popped = 1'b0;
    if (flush) begin
      scb.delete();
      pend     = 1'b0;
      halted_m = 1'b0;
      pc_nxt   = tgt;
    end else begin
      if (exp_adv) scb.push_back('{pc: pc_reg, instr: imem(pc_reg)});
      pend = exp_adv;
      if (halt_req) halted_m = 1'b1;
      pc_nxt = exp_adv ? pc_reg + 32'd4 : pc_reg;
    end
    rd_nxt = imem(pc_reg);
  endtask

  task automatic step(input bit f, input bit h, input bit r, input logic [31:0] tgt);
    drive(f, h, r);
    check_update(tgt);
  endtask

  // Reset is raised between clock edges; outputs must clear before any edge arrives.
  task automatic do_reset(input bit r);
    #1;
    reset = 1'b1;
    #1;
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk1("rst_pc_advance", bus.pc_advance, 1'b0);
    chk1("rst_halted", halted, 1'b0);
    chk32("rst_out_pc", bus.out_pc, 32'h0);
    chk32("rst_out_instr", bus.out_instr, 32'h0);
    flush    = 1'b0;
    halt_req = 1'b0;
    repeat (2) @(posedge clock);
    scb.delete();
    pend     = 1'b0;
    halted_m = 1'b0;
    popped   = 1'b0;
    pc_nxt   = '0;
    rd_nxt   = '0;
    @(posedge clock);
    #1;
    reset          = 1'b0;
    pc_reg         = '0;
    bus.pc_in      = '0;
    bus.imem_rdata = '0;
    bus.out_ready  = r;
    check_update(32'h0);
  endtask

  initial begin
    bus.pc_in      = '0;
    bus.imem_rdata = '0;
    bus.out_ready  = 1'b0;

    // streaming with decode always ready
    do_reset(1'b1);
    repeat (6) step(1'b0, 1'b0, 1'b1, 32'h0);

    // decode stalled: queue fills to DEPTH, then drains in order
    do_reset(1'b0);
    repeat (5) step(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (4) step(1'b0, 1'b0, 1'b1, 32'h0);

    // flush while issuing with one entry buffered
    repeat (3) step(1'b0, 1'b0, 1'b1, 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'h40);
    repeat (4) step(1'b0, 1'b0, 1'b1, 32'h0);

    // halt with a fetch in flight, then flush back to RUN
    step(1'b0, 1'b1, 1'b1, 32'h0);
    repeat (4) step(1'b0, 1'b0, 1'b1, 32'h0);
    step(1'b1, 1'b0, 1'b1, 32'h100);
    repeat (10) step(1'b0, 1'b0, 1'b1, 32'h0);

    // fill the queue, then asynchronous reset mid-cycle
    repeat (4) step(1'b0, 1'b0, 1'b0, 32'h0);
    do_reset(1'b1);
    repeat (6) step(1'b0, 1'b0, 1'b1, 32'h0);

    // randomised mix of backpressure, flush and halt
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 15) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 9) < 6, $urandom & 32'h0000_FFFF);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
